// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution output stage: requantisation
// arithmetic, frame sizing and the buffered output beat format.
package conv_pkg;

   // Wide enough for any IN_WIDTH up to 62 plus the rounding carry and sign.
   localparam int unsigned CALC_W    = 64;
   localparam int unsigned MAX_OUT_W = 32;

   typedef logic signed [CALC_W-1:0] calc_t;

   typedef struct packed {
      logic signed [MAX_OUT_W-1:0] data;
      logic                        last;
   } out_beat_t;

   function automatic int unsigned BEATS_PER_FRAME(input int unsigned conv_size);
      return conv_size * conv_size;
   endfunction

   // Round-half-up right shift, optional ReLU, then clamp to a signed out_width range.
   function automatic calc_t sat_shift(input calc_t       value,
                                       input int unsigned shamt,
                                       input logic        relu,
                                       input int unsigned out_width);
      calc_t acc;
      calc_t max_v;
      calc_t min_v;
      acc = value;
      if (shamt > 0) begin
         acc = acc + (calc_t'(1) <<< (shamt - 1));
      end
      acc = acc >>> shamt;
      if (relu && (acc < 0)) begin
         acc = '0;
      end
      max_v = (calc_t'(1) <<< (out_width - 1)) - calc_t'(1);
      min_v = -max_v - calc_t'(1);
      if (acc > max_v) begin
         acc = max_v;
      end else if (acc < min_v) begin
         acc = min_v;
      end
      return acc;
   endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Small synchronous FIFO with occupancy count; accepts a write while full only
// when a read frees the head entry in the same cycle.
module conv_out_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_wr, do_rd;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || rd_en);

   always_comb begin
      count_d = count_q;
      if (do_wr && !do_rd) begin
         count_d = count_q + CNT_W'(1);
      end else if (!do_wr && do_rd) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_rd) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = mem[rd_ptr_q];

   a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
      !(wr_en && full && !rd_en));

endmodule

// File: rtl/conv_output_stage.sv
// Requantises accumulator beats, stages them one cycle, buffers them in a FIFO
// and frames the output stream with a locally generated last.
module conv_output_stage
   import conv_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = 32,
   parameter int unsigned OUT_WIDTH  = 16,
   parameter int unsigned CONV_SIZE  = 26,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [$clog2(IN_WIDTH)-1:0] shift,
   input  logic                       relu_en,
   input  logic                       mult_valid,
   output logic                       mult_ready,
   input  logic signed [IN_WIDTH-1:0] mult_data,
   input  logic                       mult_last,
   output logic                       valid,
   output logic [OUT_WIDTH-1:0]       data,
   output logic                       last,
   input  logic                       ready,
   output logic                       frame_err
);

   localparam int unsigned BEATS  = BEATS_PER_FRAME(CONV_SIZE);
   localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic              stage_valid_q;
   out_beat_t         stage_q, stage_d;
   logic              frame_err_q;
   logic              accept, is_final, pop;
   logic [FCNT_W-1:0] fifo_count;
   logic              fifo_full, fifo_empty;
   out_beat_t         head;

   assign accept   = mult_valid && mult_ready;
   assign is_final = (beat_cnt_q == LAST_IDX);

   // Counts the staged beat as occupied so it always has a FIFO slot next edge;
   // depends only on registered state, never on ready.
   assign mult_ready = (fifo_count + FCNT_W'(stage_valid_q)) < FCNT_W'(FIFO_DEPTH);

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (accept) begin
         beat_cnt_d = is_final ? '0 : beat_cnt_q + CNT_W'(1);
      end
      stage_d.data = MAX_OUT_W'(sat_shift(calc_t'(mult_data), 32'(shift), relu_en,
                                          OUT_WIDTH));
      stage_d.last = is_final;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_cnt_q    <= '0;
         stage_valid_q <= 1'b0;
         stage_q       <= '0;
         frame_err_q   <= 1'b0;
      end else begin
         beat_cnt_q    <= beat_cnt_d;
         stage_valid_q <= accept;
         if (accept) begin
            stage_q <= stage_d;
         end
         // The counter is trusted; a disagreeing mult_last only raises the flag.
         if (accept && (mult_last != is_final)) begin
            frame_err_q <= 1'b1;
         end
      end
   end

   conv_out_fifo #(
      .WIDTH ($bits(out_beat_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (stage_valid_q),
      .wr_data (stage_q),
      .rd_en   (pop),
      .rd_data (head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign pop       = valid && ready;
   assign valid     = !fifo_empty;
   assign data      = fifo_empty ? '0 : head.data[OUT_WIDTH-1:0];
   assign last      = !fifo_empty && head.last;
   assign frame_err = frame_err_q;

   a_stage_has_room : assert property (@(posedge clk) disable iff (!rstn)
      !(stage_valid_q && fifo_full && !pop));

   a_stall_stable : assert property (@(posedge clk) disable iff (!rstn)
      (valid && !ready) |=> (valid && $stable(data) && $stable(last)));

endmodule

// File: tb/tb_conv_output_stage.sv
// Randomised scoreboard bench for conv_output_stage (CONV_SIZE=2, FIFO_DEPTH=4).
module tb_conv_output_stage;

   localparam int IN_W  = 32;
   localparam int OUT_W = 16;
   localparam int CS    = 2;
   localparam int DEPTH = 4;
   localparam int FRAME = CS * CS;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic [4:0]         shift = 5'd4;
   logic               relu_en = 1'b0;
   logic               mult_valid = 1'b0;
   logic               mult_ready;
   logic signed [31:0] mult_data = '0;
   logic               mult_last = 1'b0;
   logic               valid;
   logic [15:0]        data;
   logic               last;
   logic               ready = 1'b1;
   logic               frame_err;

   typedef struct {
      logic [15:0] data;
      logic        last;
      int          t;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;
   int   model_beat = 0;
   int   cyc = 0;
   bit   check_lat = 0;
   bit   rand_ready = 0;
   bit   ready_forced = 1;
   int   ready_pct = 70;
   bit   stall_prev = 0;
   logic [15:0] stall_data;
   logic        stall_last;

   conv_output_stage #(
      .IN_WIDTH   (IN_W),
      .OUT_WIDTH  (OUT_W),
      .CONV_SIZE  (CS),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .shift      (shift),
      .relu_en    (relu_en),
      .mult_valid (mult_valid),
      .mult_ready (mult_ready),
      .mult_data  (mult_data),
      .mult_last  (mult_last),
      .valid      (valid),
      .data       (data),
      .last       (last),
      .ready      (ready),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference requantisation from plain integer arithmetic.
   function automatic logic [15:0] ref_q(input longint x, input int sh, input bit relu);
      longint v;
      v = x;
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
      v = v >>> sh;
      if (relu && v < 0) v = 0;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return v[15:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   always @(negedge clk) begin
      #1;
      ready = rand_ready ? ($urandom_range(0, 99) < ready_pct) : ready_forced;
   end

   // Monitor: samples just before each rising edge.
   always @(negedge clk) begin
      exp_t e;
      #4;
      if (rstn) begin
         if (stall_prev) begin
            check("stall_valid_held", {31'b0, valid}, 32'd1);
            check("stall_data_held", {15'b0, data, last}, {15'b0, stall_data, stall_last});
         end
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_beat: got data %0h with nothing pending, required no beat",
                        data);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", {16'b0, data}, {16'b0, e.data});
               check("beat_last", {31'b0, last}, {31'b0, e.last});
               if (check_lat) check("latency", cyc - e.t, 32'd2);
            end
         end
         stall_prev = valid && !ready;
         stall_data = data;
         stall_last = last;
      end else begin
         stall_prev = 0;
      end
   end

   // One cycle of offering a beat; called at a falling edge.
   task automatic offer(input logic [31:0] d, input bit bad_last, output bit taken);
      bit el;
      el = (model_beat == FRAME - 1);
      mult_valid = 1'b1;
      mult_data  = d;
      mult_last  = bad_last ? !el : el;
      taken = mult_ready;
      if (taken) begin
         exp_q.push_back('{ref_q(longint'($signed(d)), int'(shift), relu_en), el, cyc});
         model_beat = (model_beat + 1) % FRAME;
      end
      @(negedge clk);
      mult_valid = 1'b0;
      mult_last  = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input bit bad_last);
      bit taken;
      taken = 0;
      for (int n = 0; n < 500 && !taken; n++) offer(d, bad_last, taken);
      if (!taken) begin
         checks++;
         $display("FAIL accept_timeout: mult_ready stayed 0, required 1");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || valid) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drained", exp_q.size(), 32'd0);
   endtask

   function automatic logic [31:0] rand_data();
      case ($urandom_range(0, 3))
         0: return $urandom();
         1: return 32'($signed($urandom_range(0, 2000)) - 1000);
         2: return 32'h7FFF_0000 + $urandom_range(0, 32'hFFFF);
         default: return 32'h8000_0000 + $urandom_range(0, 32'hFFFF);
      endcase
   endfunction

   initial begin
      int accepted;
      int c0;
      bit tk;
      logic [31:0] bp_data [10];

      repeat (2) @(negedge clk);
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_data", {16'b0, data}, 32'd0);
      check("rst_last", {31'b0, last}, 32'd0);
      check("rst_frame_err", {31'b0, frame_err}, 32'd0);
      check("rst_mult_ready", {31'b0, mult_ready}, 32'd1);
      rstn = 1'b1;
      @(negedge clk);

      // Basic requantisation, back-to-back with ready held high.
      shift = 5'd4;
      relu_en = 1'b0;
      check_lat = 1;
      c0 = cyc;
      send(32'h0000_0018, 0);
      send(32'hFFFF_FFE8, 0);
      send(32'h7FFF_FFFF, 0);
      send(32'h8000_0000, 0);
      check("throughput_cycles", cyc - c0, 32'd4);
      drain();

      // ReLU; two extra beats complete the frame.
      shift = 5'd0;
      relu_en = 1'b1;
      send(-32'sd5, 0);
      send(32'd7, 0);
      send(32'd100, 0);
      send(-32'sd100, 0);
      drain();
      check_lat = 0;
      relu_en = 1'b0;
      shift = 5'd3;

      // Backpressure: ten beats offered with ready low.
      ready_forced = 0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) bp_data[i] = $urandom();
      accepted = 0;
      for (int i = 0; i < 10; i++) begin
         offer(bp_data[accepted], 0, tk);
         if (tk) accepted++;
      end
      check("bp_accepted", accepted, 32'd4);
      check("bp_mult_ready_low", {31'b0, mult_ready}, 32'd0);
      ready_forced = 1;
      @(negedge clk);
      check("bp_mult_ready_rise", {31'b0, mult_ready}, 32'd1);
      for (int i = accepted; i < 10; i++) send(bp_data[i], 0);
      drain();

      // Frame error: align to a frame start, then flag beat 3 as last.
      while (model_beat != 0) send(rand_data(), 0);
      drain();
      check("frame_err_clean", {31'b0, frame_err}, 32'd0);
      send(32'd16, 0);
      send(32'd32, 0);
      send(32'd48, 1);
      check("frame_err_set", {31'b0, frame_err}, 32'd1);
      send(32'd64, 0);
      for (int i = 0; i < FRAME; i++) send(rand_data(), 0);
      drain();
      check("frame_err_sticky", {31'b0, frame_err}, 32'd1);

      // Random ready and valid gaps, 4 x 250 beats with varying quantisation.
      rand_ready = 1;
      for (int chunk = 0; chunk < 4; chunk++) begin
         shift = 5'($urandom_range(0, 31));
         relu_en = 1'($urandom_range(0, 1));
         ready_pct = 30 + 20 * chunk;
         for (int i = 0; i < 250; i++) begin
            send(rand_data(), 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         drain();
      end
      rand_ready = 0;

      // Reset with three beats buffered.
      ready_forced = 0;
      @(negedge clk);
      send(32'd1000, 0);
      send(32'd2000, 0);
      send(32'd3000, 0);
      repeat (2) @(negedge clk);
      check("pre_rst_valid", {31'b0, valid}, 32'd1);
      #3 rstn = 1'b0;
      #1;
      check("arst_valid", {31'b0, valid}, 32'd0);
      check("arst_data", {16'b0, data}, 32'd0);
      check("arst_last", {31'b0, last}, 32'd0);
      check("arst_frame_err", {31'b0, frame_err}, 32'd0);
      check("arst_mult_ready", {31'b0, mult_ready}, 32'd1);
      exp_q.delete();
      model_beat = 0;
      @(negedge clk);
      rstn = 1'b1;
      ready_forced = 1;
      @(negedge clk);
      for (int i = 0; i < FRAME + 2; i++) send(rand_data(), 0);
      drain();
      check("post_rst_frame_err", {31'b0, frame_err}, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

endmodule
